// File: rtl/io_responder.sv
// Memory-mapped GPIO/timer/scratch responder: reads are combinational from register state, writes land on the strobe edge.
// No backpressure; irq is a pure function of the status and enable flops.
module io_responder #(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       peripheral_in,
  input  logic              peripheral_we,
  output logic [31:0]       peripheral_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam logic [2:0] OFF_GPIO_OUT  = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN   = 3'd1;
  localparam logic [2:0] OFF_TMR_CTRL  = 3'd2;
  localparam logic [2:0] OFF_TMR_LOAD  = 3'd3;
  localparam logic [2:0] OFF_TMR_COUNT = 3'd4;
  localparam logic [2:0] OFF_STATUS    = 3'd5;
  localparam logic [2:0] OFF_SCRATCH   = 3'd6;

  // Register state
  logic [GPIO_W-1:0]                  gpio_out_q, gpio_out_d;
  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q;
  logic [GPIO_W-1:0]                  sync_prev_q;
  logic                               en_q, en_d;
  logic                               ar_q, ar_d;
  logic                               tmr_ie_q, tmr_ie_d;
  logic                               gpio_ie_q, gpio_ie_d;
  logic [31:0]                        load_q, load_d;
  logic [31:0]                        count_q, count_d;
  logic                               tmr_exp_q, tmr_exp_d;
  logic                               gpio_edge_q, gpio_edge_d;
  logic [31:0]                        scratch_q, scratch_d;

  // Decode
  logic              sel;
  logic [2:0]        off;
  logic              wr_en;
  logic              wr_gpo, wr_ctrl, wr_load, wr_stat, wr_scr;
  logic [GPIO_W-1:0] sync_out;
  logic              gpio_chg;
  logic              tmr_zero;
  logic              tmr_fire;
  logic              unused_addr_bits;

  assign sel      = (addr[31:29] == 3'b111);
  assign off      = addr[4:2];
  assign wr_en    = peripheral_we & sel;
  assign wr_gpo   = wr_en && (off == OFF_GPIO_OUT);
  assign wr_ctrl  = wr_en && (off == OFF_TMR_CTRL);
  assign wr_load  = wr_en && (off == OFF_TMR_LOAD);
  assign wr_stat  = wr_en && (off == OFF_STATUS);
  assign wr_scr   = wr_en && (off == OFF_SCRATCH);

  assign unused_addr_bits = ^{addr[28], addr[27:5], addr[1:0]};

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign gpio_chg = |(sync_out ^ sync_prev_q);

  assign tmr_zero = (count_q == 32'd0);
  assign tmr_fire = en_q & tmr_zero;

  always_comb begin
    gpio_out_d = wr_gpo  ? peripheral_in[GPIO_W-1:0] : gpio_out_q;
    load_d     = wr_load ? peripheral_in : load_q;
    scratch_d  = wr_scr  ? peripheral_in : scratch_q;
    ar_d       = wr_ctrl ? peripheral_in[1] : ar_q;
    tmr_ie_d   = wr_ctrl ? peripheral_in[2] : tmr_ie_q;
    gpio_ie_d  = wr_ctrl ? peripheral_in[3] : gpio_ie_q;
  end

  // Timer: CPU writes are applied after the countdown step so they take priority.
  always_comb begin
    en_d    = en_q;
    count_d = count_q;
    if (en_q) begin
      if (!tmr_zero) begin
        count_d = count_q - 32'd1;
      end else if (ar_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end
    if (wr_ctrl) begin
      en_d = peripheral_in[0];
      if (peripheral_in[0] && !en_q) begin
        count_d = load_q;
      end
    end
    if (wr_load) begin
      count_d = peripheral_in;
    end
  end

  // Set events beat a simultaneous write-one-to-clear.
  always_comb begin
    tmr_exp_d   = (tmr_exp_q   & ~(wr_stat & peripheral_in[0])) | tmr_fire;
    gpio_edge_d = (gpio_edge_q & ~(wr_stat & peripheral_in[1])) | gpio_chg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out_q  <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
      en_q        <= 1'b0;
      ar_q        <= 1'b0;
      tmr_ie_q    <= 1'b0;
      gpio_ie_q   <= 1'b0;
      load_q      <= '0;
      count_q     <= '0;
      tmr_exp_q   <= 1'b0;
      gpio_edge_q <= 1'b0;
      scratch_q   <= '0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      sync_q[0]   <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_prev_q <= sync_out;
      en_q        <= en_d;
      ar_q        <= ar_d;
      tmr_ie_q    <= tmr_ie_d;
      gpio_ie_q   <= gpio_ie_d;
      load_q      <= load_d;
      count_q     <= count_d;
      tmr_exp_q   <= tmr_exp_d;
      gpio_edge_q <= gpio_edge_d;
      scratch_q   <= scratch_d;
    end
  end

  always_comb begin
    peripheral_out = '0;
    if (sel) begin
      case (off)
        OFF_GPIO_OUT:  peripheral_out[GPIO_W-1:0] = gpio_out_q;
        OFF_GPIO_IN:   peripheral_out[GPIO_W-1:0] = sync_out;
        OFF_TMR_CTRL:  peripheral_out[3:0]        = {gpio_ie_q, tmr_ie_q, ar_q, en_q};
        OFF_TMR_LOAD:  peripheral_out             = load_q;
        OFF_TMR_COUNT: peripheral_out             = count_q;
        OFF_STATUS:    peripheral_out[1:0]        = {gpio_edge_q, tmr_exp_q};
        OFF_SCRATCH:   peripheral_out             = scratch_q;
        default:       peripheral_out             = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = (tmr_exp_q & tmr_ie_q) | (gpio_edge_q & gpio_ie_q);

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 The block SHALL have parameter GPIO_W, default 16, meaning width of the GPIO input and output ports.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning flop count of the gpio_in synchronizer.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 addr  input  32  CPU target address.
REQ-007 peripheral_in  input  32  write data from CPU.
REQ-008 peripheral_we  input  1  write strobe, one cycle per write.
REQ-009 peripheral_out  output  32  read data to CPU.
REQ-010 gpio_in  input  GPIO_W  asynchronous external inputs.
REQ-011 gpio_out  output  GPIO_W  registered external outputs.
REQ-012 irq  output  1  level interrupt to CPU interrupter input.

Function
REQ-013 Select SHALL be sel = (addr[31:28]==4'hE or 4'hF); register offset = addr[4:2].
REQ-014 Register map SHALL be: 0 GPIO_OUT RW; 1 GPIO_IN RO; 2 TMR_CTRL RW (bit0 en, bit1 autoreload, bit2 tmr_ie, bit3 gpio_ie); 3 TMR_LOAD RW 32b; 4 TMR_COUNT RO 32b; 5 STATUS W1C (bit0 tmr_exp, bit1 gpio_edge); 6 SCRATCH RW 32b; 7 reserved.
REQ-015 peripheral_out SHALL be combinational from addr and current register state (zero-cycle read latency); 0 when sel=0, offset 7, or for unused upper bits.
REQ-016 A write SHALL take effect at the clk edge where peripheral_we=1 and sel=1; writes with sel=0, to RO registers, or to offset 7 SHALL be ignored.
REQ-017 GPIO_OUT write SHALL update gpio_out on that edge from peripheral_in[GPIO_W-1:0].
REQ-018 GPIO_IN SHALL read the SYNC_STAGES-flop synchronized value; gpio_edge SHALL set when any synchronized bit changes vs. the previous synchronized value.
REQ-019 Timer: when en=1 and count!=0, count SHALL decrement by 1 each cycle.
REQ-020 When en=1 and count==0: tmr_exp SHALL set; if autoreload=1, count<=TMR_LOAD the same edge and en stays 1; else en SHALL clear to 0 and count stays 0.
REQ-021 A TMR_LOAD write SHALL also load TMR_COUNT with the written value on the same edge, overriding decrement/reload.
REQ-022 A TMR_CTRL write changing en 0->1 SHALL load count<=TMR_LOAD on that edge; count SHALL hold while en=0.
REQ-023 STATUS write SHALL clear each bit whose peripheral_in bit is 1; a set event in the same cycle SHALL win over the clear.
REQ-024 irq SHALL be registered-state derived: (tmr_exp & tmr_ie) | (gpio_edge & gpio_ie), no extra latency beyond the status flops.
REQ-025 Arithmetic SHALL be 32-bit unsigned; count never wraps below 0.

Reset
REQ-026 Asserting rst low SHALL immediately clear all registers, synchronizer flops, gpio_out, STATUS and irq to 0, regardless of clk, including mid-countdown.
REQ-027 After rst deasserts, the first write SHALL be accepted on the first rising clk edge.
REQ-028 peripheral_out during reset SHALL reflect the zeroed registers (0 for all offsets).

Verification
REQ-029 Write 0x0000_00A5 to addr 0xF000_0000, then read 0xF000_0000 -> gpio_out=0x00A5 next edge, read returns 0x0000_00A5; same write to 0x1000_0000 -> gpio_out unchanged.
REQ-030 LOAD=3, CTRL=0x5 (en, tmr_ie) -> COUNT reads 3,2,1,0 on successive cycles, then tmr_exp=1, irq=1, en=0, COUNT holds 0.
REQ-031 LOAD=2, CTRL=0x3 (autoreload) -> COUNT sequence 2,1,0,2,1,0,...; tmr_exp sets at each zero; W1C 0x1 to STATUS clears it, irq falls next edge.
REQ-032 W1C to STATUS in the same cycle the timer hits 0 -> tmr_exp remains 1.
REQ-033 gpio_in bit3 toggles 0->1 with CTRL=0x8 -> GPIO_IN reads 0x0008 after SYNC_STAGES edges, gpio_edge=1, irq=1.
REQ-034 Drop rst mid-countdown (COUNT=0x10) between clk edges -> all outputs 0 immediately; after release COUNT=0, irq=0 until reprogrammed.
